// File: rtl/instr_register_calc_if.sv
// Bus bundle for instr_register_calc: write/read request signals driven by
// the master and the registered read data, pointer and error pulses
// returned by the slave (the register file).
// When INSTR_VALID_EN is defined the bundle also carries rd_unwritten.
interface instr_register_calc_if #(
  parameter int OP_WIDTH  = 32,
  parameter int RES_WIDTH = 64,
  parameter int DEPTH     = 32
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int WORD_W = 4 + 2 * OP_WIDTH + RES_WIDTH;

  logic                       load_en;
  logic                       auto_ptr;
  logic signed [OP_WIDTH-1:0] operand_a;
  logic signed [OP_WIDTH-1:0] operand_b;
  logic [3:0]                 opcode;
  logic [PTR_W-1:0]           write_pointer;
  logic                       read_en;
  logic [PTR_W-1:0]           read_pointer;
  logic [WORD_W-1:0]          instruction_word;
  logic                       rd_valid;
  logic [PTR_W-1:0]           wr_ptr_q;
  logic                       div_err;
  logic                       illegal_op;
`ifdef INSTR_VALID_EN
  logic                       rd_unwritten;
`endif

  modport slave (
    input  load_en, auto_ptr, operand_a, operand_b, opcode, write_pointer,
           read_en, read_pointer,
`ifdef INSTR_VALID_EN
    output rd_unwritten,
`endif
    output instruction_word, rd_valid, wr_ptr_q, div_err, illegal_op
  );

  modport master (
    output load_en, auto_ptr, operand_a, operand_b, opcode, write_pointer,
           read_en, read_pointer,
`ifdef INSTR_VALID_EN
    input  rd_unwritten,
`endif
    input  instruction_word, rd_valid, wr_ptr_q, div_err, illegal_op
  );
endinterface

// File: rtl/instr_register_calc.sv
// instr_register_calc: DEPTH-slot instruction register. Each write stores
// {opcode, operand_a, operand_b, result}, with the result computed from the
// same-cycle operands. Registered read port (1-cycle latency, read-before-
// write on a same-slot collision), optional auto-incrementing write pointer.
// Optional feature macro: INSTR_VALID_EN adds per-slot written bits and the
// rd_unwritten output.
module instr_register_calc #(
  parameter int OP_WIDTH  = 32,
  parameter int RES_WIDTH = 64,
  parameter int DEPTH     = 32
) (
  input logic                  clk,
  input logic                  reset,
  instr_register_calc_if.slave bus
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int WORD_W = 4 + 2 * OP_WIDTH + RES_WIDTH;

  localparam logic [3:0] OP_ZERO  = 4'd0;
  localparam logic [3:0] OP_PASSA = 4'd1;
  localparam logic [3:0] OP_PASSB = 4'd2;
  localparam logic [3:0] OP_ADD   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_MULT  = 4'd5;
  localparam logic [3:0] OP_DIV   = 4'd6;
  localparam logic [3:0] OP_MOD   = 4'd7;

  logic signed [RES_WIDTH-1:0] a_ext;
  logic signed [RES_WIDTH-1:0] b_ext;
  logic signed [RES_WIDTH-1:0] result_c;
  logic                        div_zero_c;
  logic                        illegal_c;
  logic [PTR_W-1:0]            wr_idx;
  logic [WORD_W-1:0]           new_word;

  logic [WORD_W-1:0]           slots [DEPTH];
  logic [WORD_W-1:0]           rd_word_q;
  logic                        rd_valid_q;
  logic [PTR_W-1:0]            wr_ptr_r;
  logic                        div_err_q;
  logic                        illegal_q;

  // Extending both operands to the result width first keeps the full signed
  // product and avoids overflow on e.g. min/-1.
  assign a_ext = {{(RES_WIDTH - OP_WIDTH){bus.operand_a[OP_WIDTH-1]}}, bus.operand_a};
  assign b_ext = {{(RES_WIDTH - OP_WIDTH){bus.operand_b[OP_WIDTH-1]}}, bus.operand_b};

  // ALU: result and error flags for the instruction presented this cycle.
  always_comb begin
    result_c   = '0;
    div_zero_c = 1'b0;
    illegal_c  = 1'b0;
    case (bus.opcode)
      OP_ZERO:  result_c = '0;
      OP_PASSA: result_c = a_ext;
      OP_PASSB: result_c = b_ext;
      OP_ADD:   result_c = a_ext + b_ext;
      OP_SUB:   result_c = a_ext - b_ext;
      OP_MULT:  result_c = a_ext * b_ext;
      OP_DIV: begin
        if (b_ext == '0) div_zero_c = 1'b1;
        else             result_c   = a_ext / b_ext;
      end
      OP_MOD: begin
        if (b_ext == '0) div_zero_c = 1'b1;
        else             result_c   = a_ext % b_ext;
      end
      default:  illegal_c = 1'b1;
    endcase
  end

  assign wr_idx   = bus.auto_ptr ? wr_ptr_r : bus.write_pointer;
  assign new_word = {bus.opcode, bus.operand_a, bus.operand_b, result_c};

  // Slot storage; cleared on reset, written on load_en.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
    end else if (bus.load_en) begin
      slots[wr_idx] <= new_word;
    end
  end

  // Registered read port; sampling slots before they update gives
  // read-before-write on a same-slot collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_word_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= bus.read_en;
      if (bus.read_en) rd_word_q <= slots[bus.read_pointer];
    end
  end

  // Internal write pointer; DEPTH is a power of two so it wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= '0;
    end else if (bus.load_en && bus.auto_ptr) begin
      wr_ptr_r <= wr_ptr_r + 1'b1;
    end
  end

  // Error pulses, one cycle after the offending write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_err_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      div_err_q <= bus.load_en & div_zero_c;
      illegal_q <= bus.load_en & illegal_c;
    end
  end

`ifdef INSTR_VALID_EN
  logic [DEPTH-1:0] written_q;
  logic             rd_unwritten_q;

  // Per-slot written bits and the matching read-side flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      written_q      <= '0;
      rd_unwritten_q <= 1'b0;
    end else begin
      if (bus.read_en) rd_unwritten_q <= ~written_q[bus.read_pointer];
      if (bus.load_en) written_q[wr_idx] <= 1'b1;
    end
  end

  assign bus.rd_unwritten = rd_unwritten_q;
`endif

  assign bus.instruction_word = rd_word_q;
  assign bus.rd_valid         = rd_valid_q;
  assign bus.wr_ptr_q         = wr_ptr_r;
  assign bus.div_err          = div_err_q;
  assign bus.illegal_op       = illegal_q;
endmodule

// File: tb/tb_instr_register_calc.sv
// Directed bench for instr_register_calc. Stimulus pushes expected read
// words into a scoreboard; a negedge monitor pops and compares whenever
// rd_valid is seen.
module tb_instr_register_calc;
  localparam int OP_WIDTH  = 32;
  localparam int RES_WIDTH = 64;
  localparam int DEPTH     = 32;
  localparam int PTR_W     = $clog2(DEPTH);
  localparam int WORD_W    = 4 + 2 * OP_WIDTH + RES_WIDTH;

  typedef struct {
    logic [WORD_W-1:0] word;
    int                due;
    bit                unwritten;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  exp_t              sb [$];
  logic [WORD_W-1:0] mem [DEPTH];
  bit                wr_mask [DEPTH];
  int                model_ptr = 0;

  instr_register_calc_if #(.OP_WIDTH(OP_WIDTH), .RES_WIDTH(RES_WIDTH), .DEPTH(DEPTH)) bus_if ();

  instr_register_calc #(.OP_WIDTH(OP_WIDTH), .RES_WIDTH(RES_WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [WORD_W-1:0] act, input logic [WORD_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: act=%h req=%h", name, act, exp);
    end
  endtask

  function automatic logic [WORD_W-1:0] mk(input logic [3:0] op, input int a, input int b, input longint r);
    logic [31:0] av;
    logic [31:0] bv;
    logic [63:0] rv;
    av = a;
    bv = b;
    rv = r;
    return {op, av, bv, rv};
  endfunction

  // Scoreboard monitor.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (bus_if.rd_valid) begin
        if (sb.size() == 0) begin
          chk("rd_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("rd_word", bus_if.instruction_word, e.word);
          chk("rd_latency", WORD_W'(cyc), WORD_W'(e.due));
`ifdef INSTR_VALID_EN
          chk("rd_unwritten", WORD_W'(bus_if.rd_unwritten), WORD_W'(e.unwritten));
`endif
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        chk("rd_missing", 0, 1);
      end
    end
  end

  task automatic idle_inputs();
    bus_if.load_en       = 1'b0;
    bus_if.auto_ptr      = 1'b0;
    bus_if.operand_a     = '0;
    bus_if.operand_b     = '0;
    bus_if.opcode        = '0;
    bus_if.write_pointer = '0;
    bus_if.read_en       = 1'b0;
    bus_if.read_pointer  = '0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = '0;
      wr_mask[i] = 1'b0;
    end
    model_ptr = 0;
  endtask

  // One clock of stimulus; optional write (with hand-computed result) and read.
  task automatic step(input bit ld, input bit ap, input logic [3:0] op, input int a, input int b,
                      input int wp, input bit ren, input int rp, input longint res);
    int idx;
    exp_t e;
    bus_if.load_en       = ld;
    bus_if.auto_ptr      = ap;
    bus_if.opcode        = op;
    bus_if.operand_a     = a;
    bus_if.operand_b     = b;
    bus_if.write_pointer = PTR_W'(wp);
    bus_if.read_en       = ren;
    bus_if.read_pointer  = PTR_W'(rp);
    if (ren) begin
      e.word      = mem[rp];
      e.due       = cyc + 1;
      e.unwritten = !wr_mask[rp];
      sb.push_back(e);
    end
    if (ld) begin
      idx = ap ? model_ptr : wp;
      mem[idx]     = mk(op, a, b, res);
      wr_mask[idx] = 1'b1;
      if (ap) model_ptr = (model_ptr + 1) % DEPTH;
    end
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic wr(input bit ap, input logic [3:0] op, input int a, input int b, input int wp, input longint res);
    step(1'b1, ap, op, a, b, wp, 1'b0, 0, res);
  endtask

  task automatic rd(input int rp);
    step(1'b0, 1'b0, 4'd0, 0, 0, 0, 1'b1, rp, 0);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    sb.delete();
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    idle_inputs();
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd_valid", WORD_W'(bus_if.rd_valid), 0);
    chk("rst_word", bus_if.instruction_word, 0);
    chk("rst_wr_ptr", WORD_W'(bus_if.wr_ptr_q), 0);
    chk("rst_div_err", WORD_W'(bus_if.div_err), 0);
    chk("rst_illegal", WORD_W'(bus_if.illegal_op), 0);
    reset = 1'b0;

    // All slots read zero after reset, back-to-back.
    for (int i = 0; i < DEPTH; i++) rd(i);

    // Auto-pointer ADD and MULT.
    wr(1'b1, 4'd3, 5, -3, 0, 2);
    wr(1'b1, 4'd5, -7, 6, 0, -42);
    chk("auto_wr_ptr", WORD_W'(bus_if.wr_ptr_q), 2);
    rd(0);
    rd(1);

    // Wrap: DEPTH+1 PASSA writes from a clean pointer.
    apply_reset();
    for (int i = 0; i <= DEPTH; i++) wr(1'b1, 4'd1, i, 0, 0, longint'(i));
    chk("wrap_wr_ptr", WORD_W'(bus_if.wr_ptr_q), 1);
    rd(0);
    rd(1);
    rd(DEPTH - 1);

    // Explicit-pointer writes, error pulses and signed arithmetic corners.
    wr(1'b0, 4'd6, 9, 0, 4, 0);
    chk("div0_div_err", WORD_W'(bus_if.div_err), 1);
    chk("div0_illegal", WORD_W'(bus_if.illegal_op), 0);
    wr(1'b0, 4'd7, -7, 2, 5, -1);
    chk("mod_div_err_clear", WORD_W'(bus_if.div_err), 0);
    wr(1'b0, 4'd12, 3, 4, 6, 0);
    chk("op12_illegal", WORD_W'(bus_if.illegal_op), 1);
    chk("op12_div_err", WORD_W'(bus_if.div_err), 0);
    wr(1'b0, 4'd4, 10, 20, 7, -10);
    chk("sub_illegal_clear", WORD_W'(bus_if.illegal_op), 0);
    wr(1'b0, 4'd6, -7, 2, 8, -3);
    wr(1'b0, 4'd5, -65536, 65536, 9, -64'sd4294967296);
    wr(1'b0, 4'd7, 7, 0, 10, 0);
    chk("mod0_div_err", WORD_W'(bus_if.div_err), 1);
    chk("manual_wr_ptr_hold", WORD_W'(bus_if.wr_ptr_q), 1);
    for (int i = 4; i <= 10; i++) rd(i);
    chk("div_err_idle", WORD_W'(bus_if.div_err), 0);

    // Same-slot read and write: old contents first, new contents next.
    wr(1'b0, 4'd1, 11, 0, 3, 11);
    step(1'b1, 1'b0, 4'd2, 0, 22, 3, 1'b1, 3, 22);
    rd(3);

    // Reset while a read is in flight, read_en held high.
    bus_if.read_en      = 1'b1;
    bus_if.read_pointer = PTR_W'(3);
    @(posedge clk);
    #1;
    reset = 1'b1;
    sb.delete();
    #1;
    chk("midrst_rd_valid", WORD_W'(bus_if.rd_valid), 0);
    chk("midrst_word", bus_if.instruction_word, 0);
    @(posedge clk);
    #1;
    chk("midrst_hold_valid", WORD_W'(bus_if.rd_valid), 0);
    bus_if.read_en = 1'b0;
    clear_model();
    reset = 1'b0;
    chk("midrst_wr_ptr", WORD_W'(bus_if.wr_ptr_q), 0);
    rd(3);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", WORD_W'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
